// File: rtl/mem_line_seq.sv
// Line-transfer sequencer: arbitrates icache/dcache onto one nibble-serial memory port and
// moves a whole line through a local buffer so cache-side strobes stay contiguous.
module mem_line_seq #(
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned PA          = 22,
  parameter int unsigned LB          = $clog2(LINE_LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_req,
  input  logic             d_push,
  input  logic [PA-LB-1:0] d_tag,
  input  logic [3:0]       d_dwrite,
  output logic             d_rstrobe,
  output logic             d_wstrobe,
  input  logic             i_req,
  input  logic [PA-LB-1:0] i_tag,
  output logic             i_wstrobe,
  output logic [3:0]       dread,
  output logic             m_start,
  output logic             m_write,
  output logic [PA-LB-1:0] m_addr,
  output logic [3:0]       m_wdata,
  input  logic [3:0]       m_rdata,
  input  logic             m_rdy,
  output logic             busy
);

  localparam int unsigned NIB = 2 * LINE_LENGTH;
  localparam int unsigned KW  = $clog2(NIB);
  localparam logic [KW-1:0] KLast = KW'(NIB - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCUnload,
    StMCmd,
    StMWdata,
    StMRdata,
    StCLoad,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic             rr_last_q, rr_last_d;  // 0: dcache granted last, 1: icache
  logic             push_q, push_d;
  logic             gnt_i_q, gnt_i_d;
  logic [PA-LB-1:0] addr_q, addr_d;
  logic [3:0]       line_buf_q [NIB];
  logic             buf_we;
  logic [3:0]       buf_wdata;
  logic             arb_i;
  logic             k_last;

  // On a tie the requester that was not served last wins.
  assign arb_i  = i_req && (!d_req || !rr_last_q);
  assign k_last = (k_q == KLast);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    rr_last_d = rr_last_q;
    push_d    = push_q;
    gnt_i_d   = gnt_i_q;
    addr_d    = addr_q;
    buf_we    = 1'b0;
    buf_wdata = d_dwrite;
    unique case (state_q)
      StIdle: begin
        if (d_req || i_req) begin
          rr_last_d = arb_i;
          gnt_i_d   = arb_i;
          push_d    = !arb_i && d_push;
          addr_d    = arb_i ? i_tag : d_tag;
          k_d       = '0;
          state_d   = (!arb_i && d_push) ? StCUnload : StMCmd;
        end
      end
      StCUnload: begin
        buf_we = 1'b1;
        if (k_last) begin
          k_d     = '0;
          state_d = StMCmd;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StMCmd: begin
        k_d     = '0;
        state_d = push_q ? StMWdata : StMRdata;
      end
      StMWdata: begin
        if (m_rdy) begin
          if (k_last) begin
            k_d     = '0;
            state_d = StDone;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StMRdata: begin
        if (m_rdy) begin
          buf_we    = 1'b1;
          buf_wdata = m_rdata;
          if (k_last) begin
            k_d     = '0;
            state_d = StCLoad;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StCLoad: begin
        if (k_last) begin
          k_d     = '0;
          state_d = StDone;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      StDone: begin
        k_d     = '0;
        state_d = StIdle;
      end
      default: begin
        k_d     = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      rr_last_q <= 1'b0;
      push_q    <= 1'b0;
      gnt_i_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      rr_last_q <= rr_last_d;
      push_q    <= push_d;
      gnt_i_q   <= gnt_i_d;
      addr_q    <= addr_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NIB; i++) line_buf_q[i] <= '0;
    end else if (buf_we) begin
      line_buf_q[k_q] <= buf_wdata;
    end
  end

  // Outputs decode straight from state so an async reset drops them immediately.
  assign busy      = (state_q != StIdle);
  assign d_rstrobe = (state_q == StCUnload);
  assign d_wstrobe = (state_q == StCLoad) && !gnt_i_q;
  assign i_wstrobe = (state_q == StCLoad) && gnt_i_q;
  assign m_start   = (state_q == StMCmd);
  assign m_write   = (state_q == StMCmd) && push_q;
  assign m_addr    = addr_q;
  assign dread     = (state_q == StCLoad) ? line_buf_q[k_q] : 4'h0;
  assign m_wdata   = (state_q == StMWdata) ? line_buf_q[k_q] : 4'h0;

endmodule

// File: tb/tb_mem_line_seq.sv
// Scoreboard bench for mem_line_seq: a negedge monitor plays memory and pops expected
// commands, write nibbles and fill nibbles; scenario tasks drive requests and check timing.
module tb_mem_line_seq;

  localparam int NIB = 8;
  localparam int TW  = 20;

  logic          clk;
  logic          reset;
  logic          d_req, d_push, i_req, m_rdy;
  logic [TW-1:0] d_tag, i_tag, m_addr;
  logic [3:0]    d_dwrite, dread, m_wdata, m_rdata;
  logic          d_rstrobe, d_wstrobe, i_wstrobe, m_start, m_write, busy;

  int chk;
  int pass;

  logic [3:0]  unload_src [$];
  logic [3:0]  rd_src     [$];
  logic [3:0]  exp_wdata  [$];
  logic [4:0]  exp_fill   [$];  // {is_icache, nibble}
  logic [20:0] exp_cmd    [$];  // {write, line address}

  int   stall_mode;
  bit   mem_active, mem_wr;
  int   mem_cnt, mem_cyc, stall_left;
  int   rs_run, ws_run;
  logic mon_r;
  logic [4:0]  mon_e;
  logic [20:0] mon_c;

  mem_line_seq dut (
    .clk      (clk),
    .reset    (reset),
    .d_req    (d_req),
    .d_push   (d_push),
    .d_tag    (d_tag),
    .d_dwrite (d_dwrite),
    .d_rstrobe(d_rstrobe),
    .d_wstrobe(d_wstrobe),
    .i_req    (i_req),
    .i_tag    (i_tag),
    .i_wstrobe(i_wstrobe),
    .dread    (dread),
    .m_start  (m_start),
    .m_write  (m_write),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rdata  (m_rdata),
    .m_rdy    (m_rdy),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor and memory model: everything sampled and driven on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      rs_run     = 0;
      ws_run     = 0;
      mem_active = 0;
      m_rdy      = 1'b0;
    end else begin
      if (d_rstrobe) begin
        rs_run++;
        d_dwrite = (unload_src.size() != 0) ? unload_src.pop_front() : 4'h0;
      end else if (rs_run != 0) begin
        chk++;
        if (rs_run != NIB) $display("FAIL rstrobe_run: got %0d cycles, want %0d", rs_run, NIB);
        else pass++;
        rs_run = 0;
      end

      if (d_wstrobe || i_wstrobe) begin
        ws_run++;
        chk++;
        if (exp_fill.size() == 0) begin
          $display("FAIL fill: unexpected strobe i=%b d=%b dread=%h", i_wstrobe, d_wstrobe, dread);
        end else begin
          mon_e = exp_fill.pop_front();
          if ({i_wstrobe, d_wstrobe, dread} !== {mon_e[4], ~mon_e[4], mon_e[3:0]})
            $display("FAIL fill: got i=%b d=%b dread=%h, want i=%b d=%b dread=%h",
                     i_wstrobe, d_wstrobe, dread, mon_e[4], ~mon_e[4], mon_e[3:0]);
          else pass++;
        end
      end else if (ws_run != 0) begin
        chk++;
        if (ws_run != NIB) $display("FAIL wstrobe_run: got %0d cycles, want %0d", ws_run, NIB);
        else pass++;
        ws_run = 0;
      end

      if (m_start) begin
        chk++;
        if (exp_cmd.size() == 0) begin
          $display("FAIL cmd: unexpected m_start write=%b addr=%h", m_write, m_addr);
        end else begin
          mon_c = exp_cmd.pop_front();
          if ({m_write, m_addr} !== mon_c)
            $display("FAIL cmd: got write=%b addr=%h, want write=%b addr=%h",
                     m_write, m_addr, mon_c[20], mon_c[19:0]);
          else pass++;
        end
        mem_active = 1;
        mem_wr     = m_write;
        mem_cnt    = 0;
        mem_cyc    = 0;
        stall_left = 5;
        m_rdy      = 1'b0;
      end else if (mem_active) begin
        case (stall_mode)
          1:       mon_r = (mem_cyc % 2 == 0);
          2: begin
            if (mem_cnt == 3 && stall_left > 0) begin
              mon_r = 1'b0;
              stall_left--;
            end else begin
              mon_r = 1'b1;
            end
          end
          default: mon_r = 1'b1;
        endcase
        mem_cyc++;
        if (mem_wr) begin
          chk++;
          if (exp_wdata.size() == 0) $display("FAIL wdata: got %h, none expected", m_wdata);
          else if (m_wdata !== exp_wdata[0])
            $display("FAIL wdata: got %h, want %h", m_wdata, exp_wdata[0]);
          else pass++;
          if (mon_r && exp_wdata.size() != 0) mon_e[3:0] = exp_wdata.pop_front();
        end else if (mon_r) begin
          m_rdata = (rd_src.size() != 0) ? rd_src.pop_front() : 4'h0;
        end
        m_rdy = mon_r;
        if (mon_r) begin
          mem_cnt++;
          if (mem_cnt == NIB) mem_active = 0;
        end
      end else begin
        m_rdy = 1'b0;
      end
    end
  end

  task automatic queue_pull(input bit is_i, input logic [TW-1:0] addr, input logic [3:0] base);
    exp_cmd.push_back({1'b0, addr});
    for (int n = 0; n < NIB; n++) begin
      rd_src.push_back(base + 4'(n));
      exp_fill.push_back({is_i, base + 4'(n)});
    end
  endtask

  task automatic queue_push(input logic [TW-1:0] addr);
    exp_cmd.push_back({1'b1, addr});
    for (int n = 0; n < NIB; n++) begin
      unload_src.push_back(4'hF - 4'(n));
      exp_wdata.push_back(4'hF - 4'(n));
    end
  endtask

  task automatic wait_idle(input int budget, output int busy_n, output bit ok);
    busy_n = 0;
    ok     = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy) busy_n++;
      else begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    d_req = 0; i_req = 0; d_push = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    chk++;
    if ({d_rstrobe, d_wstrobe, i_wstrobe, m_start, m_write, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b, want 000000",
               {d_rstrobe, d_wstrobe, i_wstrobe, m_start, m_write, busy});
    else pass++;
    chk++;
    if ({dread, m_wdata} !== 8'h00) $display("FAIL reset_data: got %h, want 00", {dread, m_wdata});
    else pass++;
    chk++;
    if (m_addr !== '0) $display("FAIL reset_addr: got %h, want 0", m_addr);
    else pass++;
    do_reset();
  endtask

  task automatic test_icache_fill();
    int n; bit ok;
    stall_mode = 0;
    i_tag = 20'h01234;
    queue_pull(1, 20'h01234, 4'h1);
    @(negedge clk); i_req = 1;
    @(negedge clk); i_req = 0;
    wait_idle(100, n, ok);
    chk++;
    if (!ok || n + 1 != 18) $display("FAIL icache_busy: got %0d cycles (ok=%b), want 18", n + 1, ok);
    else pass++;
  endtask

  task automatic test_dcache_push();
    int n; bit ok;
    stall_mode = 1;
    d_tag = 20'h000A5;
    queue_push(20'h000A5);
    @(negedge clk); d_req = 1; d_push = 1;
    @(negedge clk); d_req = 0; d_push = 0;
    wait_idle(100, n, ok);
    chk++;
    if (!ok || n + 1 != 25) $display("FAIL push_busy: got %0d cycles (ok=%b), want 25", n + 1, ok);
    else pass++;
  endtask

  task automatic test_read_stall();
    int n; bit ok;
    stall_mode = 2;
    d_tag = 20'h0003C;
    queue_pull(0, 20'h0003C, 4'h3);
    @(negedge clk); d_req = 1;
    @(negedge clk); d_req = 0;
    wait_idle(100, n, ok);
    chk++;
    if (!ok || n + 1 != 23) $display("FAIL stall_busy: got %0d cycles (ok=%b), want 23", n + 1, ok);
    else pass++;
  endtask

  task automatic test_arbitration();
    int n; bit ok; bit is_i;
    stall_mode = 0;
    do_reset();
    i_tag = 20'h11111;
    d_tag = 20'h22222;
    for (int r = 0; r < 3; r++) begin
      is_i = (r % 2 == 0);
      queue_pull(is_i, is_i ? 20'h11111 : 20'h22222, 4'(4 * r));
      @(negedge clk); d_req = 1; i_req = 1;
      @(negedge clk); d_req = 0; i_req = 0;
      wait_idle(100, n, ok);
      chk++;
      if (!ok || n + 1 != 18) $display("FAIL arb_round%0d: got %0d cycles (ok=%b), want 18", r, n + 1, ok);
      else pass++;
    end
  endtask

  task automatic test_push_then_pull();
    int gaps; bit dpull_seen; bit ok;
    stall_mode = 0;
    d_tag = 20'h0BEEF;
    i_tag = 20'h0CAFE;
    queue_push(20'h0BEEF);
    queue_pull(1, 20'h0CAFE, 4'h5);
    queue_pull(0, 20'h0BEEF, 4'hA);
    gaps = 0; dpull_seen = 0; ok = 0;
    @(negedge clk); d_req = 1; d_push = 1;
    @(negedge clk); d_push = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c == 3) i_req = 1;
      if (m_start && m_addr == 20'h0CAFE) i_req = 0;
      if (m_start && !m_write && m_addr == 20'h0BEEF) begin
        d_req = 0;
        dpull_seen = 1;
      end
      if (!busy) begin
        if (dpull_seen) begin
          ok = 1;
          break;
        end
        gaps++;
      end
    end
    d_req = 0; i_req = 0;
    chk++;
    if (!ok || gaps != 2) $display("FAIL push_pull_gaps: got %0d idle gaps (ok=%b), want 2", gaps, ok);
    else pass++;
  endtask

  task automatic test_reset_mid();
    int n; int strobes; bit ok;
    stall_mode = 0;
    i_tag = 20'h07777;
    queue_pull(1, 20'h07777, 4'h9);
    strobes = 0;
    @(negedge clk); i_req = 1;
    @(negedge clk); i_req = 0;
    for (int c = 0; c < 60 && strobes < 4; c++) begin
      @(negedge clk);
      if (i_wstrobe) strobes++;
    end
    #1 reset = 1'b0;
    #1;
    chk++;
    if ({d_wstrobe, i_wstrobe, d_rstrobe} !== 3'b0 || strobes != 4)
      $display("FAIL reset_mid_strobe: got %b after %0d strobes, want 000 after 4",
               {d_wstrobe, i_wstrobe, d_rstrobe}, strobes);
    else pass++;
    chk++;
    if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b, want 0", busy);
    else pass++;
    exp_fill.delete();
    rd_src.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    d_tag = 20'h00666;
    queue_pull(0, 20'h00666, 4'h6);
    @(negedge clk); d_req = 1;
    @(negedge clk); d_req = 0;
    wait_idle(100, n, ok);
    chk++;
    if (!ok || n + 1 != 18) $display("FAIL reset_mid_resume: got %0d cycles (ok=%b), want 18", n + 1, ok);
    else pass++;
  endtask

  initial begin
    chk = 0; pass = 0; stall_mode = 0;
    reset = 1'b0;
    d_req = 0; d_push = 0; i_req = 0; m_rdy = 0;
    d_tag = '0; i_tag = '0; d_dwrite = '0; m_rdata = '0;
    test_reset();
    test_icache_fill();
    test_dcache_push();
    test_read_stall();
    test_arbitration();
    test_push_then_pull();
    test_reset_mid();
    repeat (3) @(negedge clk);
    chk++;
    if (exp_cmd.size() + exp_fill.size() + exp_wdata.size() + rd_src.size() + unload_src.size() != 0)
      $display("FAIL drain: got cmd=%0d fill=%0d wdata=%0d rd=%0d unload=%0d left, want all 0",
               exp_cmd.size(), exp_fill.size(), exp_wdata.size(), rd_src.size(), unload_src.size());
    else pass++;
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule

// File: doc/mem_line_seq.md
Name: mem_line_seq

Overview:
- Line-transfer sequencer and arbiter between the icache, the dcache and one shared nibble-serial memory port.
- Grants the port to one cache at a time and runs a whole-line writeback (push) or fill (pull) through a one-line buffer.
- The buffer is required because cache-side strobes must arrive on consecutive cycles (a cache's nibble offset clears on any gap), while the memory side may stall between nibbles.

Parameters:
- LINE_LENGTH, 4, cache line length in bytes; transfer length is NIB = 2*LINE_LENGTH nibbles.
- PA, 22, physical address width.
- LB, $clog2(LINE_LENGTH), line-offset bit count; line address is [PA-1:LB].

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- d_req  in  1  dcache access pending and not hit.
- d_push  in  1  dcache must write back a dirty line (sampled at grant).
- d_tag  in  PA-LB  dcache line address (victim on push, fill address on pull).
- d_dwrite  in  4  dcache outgoing nibble, valid in the cycle d_rstrobe is high.
- d_rstrobe  out  1  dcache unload strobe.
- d_wstrobe  out  1  dcache fill strobe.
- i_req  in  1  icache miss pending.
- i_tag  in  PA-LB  icache fill line address.
- i_wstrobe  out  1  icache fill strobe.
- dread  out  4  fill nibble to both caches, valid with either wstrobe.
- m_start  out  1  one-cycle command pulse to memory.
- m_write  out  1  command is a write; valid with m_start.
- m_addr  out  PA-LB  line address; held from grant until DONE.
- m_wdata  out  4  write nibble.
- m_rdata  in  4  read nibble.
- m_rdy  in  1  a nibble transfers this cycle; memory never asserts it in the m_start cycle.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values: all strobes, m_start, m_write and busy are 0; dread, m_wdata and m_addr are 0; state IDLE; rr_last = 0 (dcache).
- Arbitration happens in IDLE only.
  - Candidates are d_req and i_req.
  - If both are high, grant the one not equal to rr_last.
  - rr_last updates on every grant.
  - On grant: latch the requester tag into m_addr; latch d_push into a push flag (the icache always pulls).
- States and transitions:
  - IDLE -> C_UNLOAD if dcache is granted with push.
  - IDLE -> M_CMD otherwise (pull).
  - C_UNLOAD: exactly NIB consecutive cycles with d_rstrobe = 1. Nibble counter k runs 0..NIB-1; buf[k] <= d_dwrite each cycle. After k = NIB-1 -> M_CMD.
  - M_CMD: one cycle with m_start = 1 and m_write = push. Then -> M_WDATA on push, M_RDATA on pull. Clear k.
  - M_WDATA: m_wdata = buf[k]. On m_rdy, k++. On m_rdy with k = NIB-1 -> DONE.
  - M_RDATA: on m_rdy, buf[k] <= m_rdata and k++. On m_rdy with k = NIB-1 -> C_LOAD, clear k.
  - C_LOAD: exactly NIB consecutive cycles. The granted cache's wstrobe = 1 and dread = buf[k] (combinational on k). After k = NIB-1 -> DONE.
  - DONE: one cycle with all strobes low, letting the cache's valid/dirty/hit settle. -> IDLE.
- A dcache push is one grant only. The following pull is a new request re-arbitrated in IDLE, so a pending icache miss may be serviced in between.
- Strobe contiguity: d_rstrobe, d_wstrobe and i_wstrobe are never deasserted mid-burst. Memory stalls (m_rdy low) only affect the M_* states.
- Only the granted cache receives strobes; the other cache's strobes stay 0.
- Request changes after grant are ignored until IDLE.
- The nibble counter is $clog2(NIB) bits and never wraps mid-transfer; it is cleared on every state entry.
- m_rdy outside M_WDATA and M_RDATA is ignored.
- Reset asserted mid-transfer: immediate return to IDLE; strobes drop asynchronously. Partial cache state is abandoned; the caches are reset by the same net.
- Latency, dcache pull with m_rdy always high after m_start: 1 (M_CMD) + NIB + NIB + 1 (DONE) cycles from grant to IDLE.

Test Plan:
- icache miss, i_tag=0x1234, m_rdy high every cycle, m_rdata = 1..8 -> one m_start with m_write=0 and m_addr=0x1234. Then 8 contiguous i_wstrobe with dread = 1,2,...,8. d_wstrobe stays 0. busy for 18 cycles.
- dcache push: d_tag=0x0A5, d_dwrite = F,E,...,8 over 8 cycles -> 8 contiguous d_rstrobe, then m_start with m_write=1. m_wdata presents F..8, one per m_rdy, with m_rdy toggling 1,0,1,0 so each nibble holds through its stall. Then DONE.
- Memory stall on read: m_rdy low for 5 cycles between nibbles 3 and 4 -> no wstrobe during the stall. Cache load is still 8 contiguous strobes carrying the correct nibbles.
- d_req and i_req asserted together from reset -> icache granted first (rr_last=d). A second simultaneous pair -> dcache granted. Alternation repeats.
- Push then pull, with i_req arriving during the push -> order is push, icache fill, dcache fill, each with a one-cycle DONE gap.
- Reset pulled low at cycle 4 of C_LOAD -> strobes 0 in the same cycle, busy 0, and a fresh request after release completes normally.
